quadrature_decoder: RTL and testbench
=====================================

// Module: quadrature_decoder
// PURPOSE
//  Decodes a rotary encoder's A/B quadrature pair into position, direction and step events.
//  Sits directly downstream of two debounce_switch instances; inputs are debounced and
//  synchronous to in_clk. Output drives UI/menu logic: one step pulse per mechanical detent.
// PARAMETERS
//  POS_BITS          8  width of the unsigned position counter
//  STEPS_PER_DETENT  4  valid quadrature transitions per detent (1, 2 or 4)
//  ACC_BITS  $clog2(STEPS_PER_DETENT)+1  width of the signed sub-detent accumulator
// PORTS
//  in_clk     in   1         system clock
//  in_rst     in   1         asynchronous, active-low reset
//  in_a       in   1         debounced encoder channel A
//  in_b       in   1         debounced encoder channel B
//  in_clear   in   1         sync clear: position, accumulator, error
//  out_pos    out  POS_BITS  current position
//  out_step   out  1         one-cycle pulse per completed detent
//  out_dir    out  1         direction of the last detent (1 = CW/up, 0 = CCW/down)
//  out_error  out  1         sticky flag: illegal transition (A and B changed together)
// BEHAVIOUR
//  - Reset (in_rst=0, async): out_pos=0, out_step=0, out_dir=0, out_error=0, acc=0,
//    ab_q=00, primed=0.
//  - First edge after reset release: ab_q <= {in_a,in_b}, primed <= 1. No transition
//    is evaluated, so no false error for any input level at release.
//  - Every later edge: decode ab_q -> {in_a,in_b} (Gray order 00->01->11->10->00 = INC,
//    reverse = DEC, equal = NONE, both bits differ = ILLEGAL). ab_q <= {in_a,in_b}.
//  - INC: if acc == STEPS_PER_DETENT-1 then acc<=0, out_pos+1, out_step<=1, out_dir<=1;
//    else acc+1. DEC mirrors this: acc == -(STEPS_PER_DETENT-1) -> pos-1, out_dir<=0.
//  - Direction reversal mid-detent moves acc back toward 0. No step until full +/-S.
//  - ILLEGAL: acc<=0, out_error<=1 (held until in_clear or reset). Position unchanged.
//  - out_step is registered: high the single cycle after the edge that completes the detent.
//    Latency from input change to out_step/out_pos update is one in_clk edge.
//  - out_pos wraps modulo 2^POS_BITS (255+1 -> 0, 0-1 -> 255).
//  - in_clear wins over a transition in the same cycle: pos=0, acc=0, out_error=0,
//    out_step=0. ab_q still samples the inputs, so the next edge decodes correctly.
//  - Reset mid-detent discards the partial accumulator and re-primes.
// CONFIGURATION
//  QUAD_SATURATE_EN defined: out_pos saturates at 0 and 2^POS_BITS-1. A detent at the
//    limit still pulses out_step and sets out_dir; out_pos holds.
//  Undefined (default): out_pos wraps as above.
// STRUCTURE
//  Package quad_pkg:
//   - typedef enum logic[1:0] {TR_NONE, TR_INC, TR_DEC, TR_ILLEGAL} t_quad_trans;
//   - function t_quad_trans quad_decode(logic[1:0] prev, logic[1:0] cur).
//  No sub-module inside: one always_ff for registers, one always_comb for next-state.
//  Natural parent: quadrature_input = 2x debounce_switch + quadrature_decoder.
// TESTING (POS_BITS=8, STEPS_PER_DETENT=4, inputs held >=2 cycles per state)
//  1 inputs=11 during reset, release, hold 10 cycles
//    -> out_error=0, out_pos=0, out_step never high.
//  2 00->01->11->10->00
//    -> out_step high exactly 1 cycle after the 4th change, out_dir=1, out_pos=1.
//  3 from pos=0: 00->10->11->01->00
//    -> out_pos=255, out_dir=0.
//    With QUAD_SATURATE_EN: out_pos=0, out_step still pulses.
//  4 00->11, then 11->10->00->01
//    -> out_error=1 and stays set; acc was zeroed, so no step after those 3 transitions.
//  5 in_clear asserted on the same edge as the 4th CW transition
//    -> out_pos=0, out_step=0, out_error=0.
//  6 00->01->11->01->00, then in_rst=0 pulse mid-detent
//    -> no step pulse; after reset all outputs are 0 and the next full detent gives out_pos=1.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and the Gray-code transition decoder for the quadrature decoder.
package quad_pkg;

    typedef enum logic [1:0] {TR_NONE, TR_INC, TR_DEC, TR_ILLEGAL} t_quad_trans;

    // Forward (CW) order is 00 -> 01 -> 11 -> 10 -> 00; the reverse order is a decrement.
    function automatic t_quad_trans quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] fwd;
        case (prev)
            2'b00:   fwd = 2'b01;
            2'b01:   fwd = 2'b11;
            2'b11:   fwd = 2'b10;
            default: fwd = 2'b00;
        endcase
        if (prev == cur)
            return TR_NONE;
        else if ((prev ^ cur) == 2'b11)
            return TR_ILLEGAL;
        else if (cur == fwd)
            return TR_INC;
        else
            return TR_DEC;
    endfunction

endpackage

// File: rtl/quadrature_decoder.sv
// Rotary encoder A/B decoder: position counter, detent step pulse, direction, sticky error.
// Define QUAD_SATURATE_EN to make the position saturate at its limits instead of wrapping.
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int unsigned POS_BITS         = 8,
    parameter int unsigned STEPS_PER_DETENT = 4,
    parameter int unsigned ACC_BITS         = $clog2(STEPS_PER_DETENT) + 1
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_a,
    input  logic                in_b,
    input  logic                in_clear,
    output logic [POS_BITS-1:0] out_pos,
    output logic                out_step,
    output logic                out_dir,
    output logic                out_error
);

    localparam logic signed [ACC_BITS-1:0] ACC_MAX = ACC_BITS'(STEPS_PER_DETENT - 1);
    localparam logic signed [ACC_BITS-1:0] ACC_MIN = -ACC_MAX;

    logic [POS_BITS-1:0]        pos_q, pos_d;
    logic signed [ACC_BITS-1:0] acc_q, acc_d;
    logic [1:0]                 ab_q, ab_d;
    logic                       primed_q, primed_d;
    logic                       step_q, step_d;
    logic                       dir_q, dir_d;
    logic                       err_q, err_d;
    t_quad_trans                trans;

    always_comb begin
        pos_d    = pos_q;
        acc_d    = acc_q;
        dir_d    = dir_q;
        err_d    = err_q;
        step_d   = 1'b0;
        ab_d     = {in_a, in_b};
        primed_d = 1'b1;
        trans    = quad_decode(ab_q, {in_a, in_b});

        // ab_q keeps sampling during clear so the following edge decodes from the true state.
        if (in_clear) begin
            pos_d = '0;
            acc_d = '0;
            err_d = 1'b0;
        end else if (primed_q) begin
            case (trans)
                TR_INC: begin
                    if (acc_q == ACC_MAX) begin
                        acc_d  = '0;
                        step_d = 1'b1;
                        dir_d  = 1'b1;
`ifdef QUAD_SATURATE_EN
                        if (pos_q != '1) pos_d = pos_q + 1'b1;
`else
                        pos_d = pos_q + 1'b1;
`endif
                    end else begin
                        acc_d = acc_q + 1'b1;
                    end
                end
                TR_DEC: begin
                    if (acc_q == ACC_MIN) begin
                        acc_d  = '0;
                        step_d = 1'b1;
                        dir_d  = 1'b0;
`ifdef QUAD_SATURATE_EN
                        if (pos_q != '0) pos_d = pos_q - 1'b1;
`else
                        pos_d = pos_q - 1'b1;
`endif
                    end else begin
                        acc_d = acc_q - 1'b1;
                    end
                end
                TR_ILLEGAL: begin
                    acc_d = '0;
                    err_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            pos_q    <= '0;
            acc_q    <= '0;
            ab_q     <= 2'b00;
            primed_q <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            acc_q    <= acc_d;
            ab_q     <= ab_d;
            primed_q <= primed_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

    assign out_pos   = pos_q;
    assign out_step  = step_q;
    assign out_dir   = dir_q;
    assign out_error = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed self-checking bench for quadrature_decoder (POS_BITS=8, STEPS_PER_DETENT=4).
module tb_quadrature_decoder;

    logic       clk;
    logic       rst_n;
    logic       a, b;
    logic       clear;
    logic [7:0] pos;
    logic       step, dir, err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    quadrature_decoder #(
        .POS_BITS         (8),
        .STEPS_PER_DETENT (4)
    ) dut (
        .in_clk    (clk),
        .in_rst    (rst_n),
        .in_a      (a),
        .in_b      (b),
        .in_clear  (clear),
        .out_pos   (pos),
        .out_step  (step),
        .out_dir   (dir),
        .out_error (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold reset with the given input levels, release, then let one edge prime the decoder.
    task automatic do_reset(input logic [1:0] ab);
        @(negedge clk);
        rst_n = 1'b0;
        {a, b} = ab;
        clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Change inputs on a falling edge, check out_step one edge later, hold a second cycle.
    task automatic move(input string tag, input logic [1:0] ab, input logic exp_step);
        {a, b} = ab;
        @(negedge clk);
        check(tag, step, exp_step);
        @(negedge clk);
        if (exp_step) check({tag, "_pulse_end"}, step, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        {a, b} = 2'b11;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pos", pos, 0);
        check("rst_err", err, 0);
        check("rst_dir", dir, 0);

        // 1: inputs at 11 across release must not raise an error or step
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t1_step", step, 0);
            check("t1_err", err, 0);
        end
        check("t1_pos", pos, 0);

        // 2: one CW detent
        do_reset(2'b00);
        move("t2_m1", 2'b01, 0);
        move("t2_m2", 2'b11, 0);
        move("t2_m3", 2'b10, 0);
        move("t2_m4", 2'b00, 1);
        check("t2_dir", dir, 1);
        check("t2_pos", pos, 1);

        // 3: one CCW detent from 0
        do_reset(2'b00);
        move("t3_m1", 2'b10, 0);
        move("t3_m2", 2'b11, 0);
        move("t3_m3", 2'b01, 0);
        move("t3_m4", 2'b00, 1);
        check("t3_dir", dir, 0);
`ifdef QUAD_SATURATE_EN
        check("t3_pos", pos, 0);
`else
        check("t3_pos", pos, 255);
`endif
        move("t3_m5", 2'b01, 0);
        move("t3_m6", 2'b11, 0);
        move("t3_m7", 2'b10, 0);
        move("t3_m8", 2'b00, 1);
`ifdef QUAD_SATURATE_EN
        check("t3_pos_up", pos, 1);
`else
        check("t3_pos_wrap", pos, 0);
`endif

        // 4: illegal jump, sticky error, accumulator zeroed
        do_reset(2'b00);
        move("t4_ill", 2'b11, 0);
        check("t4_err", err, 1);
        move("t4_m1", 2'b10, 0);
        move("t4_m2", 2'b00, 0);
        move("t4_m3", 2'b01, 0);
        check("t4_err_held", err, 1);
        check("t4_pos", pos, 0);
        move("t4_m4", 2'b11, 1);
        check("t4_pos_after", pos, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t4_clr_err", err, 0);
        check("t4_clr_pos", pos, 0);

        // 5: clear on the same edge as the completing transition
        do_reset(2'b00);
        move("t5_ill", 2'b11, 0);
        move("t5_m1", 2'b10, 0);
        move("t5_m2", 2'b00, 0);
        move("t5_m3", 2'b01, 0);
        {a, b} = 2'b11;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t5_pos", pos, 0);
        check("t5_step", step, 0);
        check("t5_err", err, 0);
        @(negedge clk);
        move("t5_n1", 2'b10, 0);
        move("t5_n2", 2'b00, 0);
        move("t5_n3", 2'b01, 0);
        move("t5_n4", 2'b11, 1);
        check("t5_pos_next", pos, 1);

        // 6: reversal returns to zero, then reset mid-detent
        do_reset(2'b00);
        move("t6_m1", 2'b01, 0);
        move("t6_m2", 2'b11, 0);
        move("t6_m3", 2'b01, 0);
        move("t6_m4", 2'b00, 0);
        move("t6_m5", 2'b01, 0);
        move("t6_m6", 2'b11, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_pos", pos, 0);
        check("t6_rst_step", step, 0);
        check("t6_rst_dir", dir, 0);
        check("t6_rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        move("t6_n1", 2'b10, 0);
        move("t6_n2", 2'b00, 0);
        move("t6_n3", 2'b01, 0);
        move("t6_n4", 2'b11, 1);
        check("t6_pos", pos, 1);
        check("t6_dir", dir, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
